// File: rtl/sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// sub_bytes_iter
//
// Iterative AES-128 SubBytes / InvSubBytes stage. A captured 128-bit state is
// substituted NUM_LANES columns per cycle through a shared set of forward and
// inverse S-box ROMs. The finished state is held on sb_o until the downstream
// stage (shift_rows) accepts it.
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   enc_or_dec_i  1 = forward S-box (encrypt), 0 = inverse S-box (decrypt),
//                 sampled when a new state is accepted
//   sb_valid_i    upstream presents a valid state on sb_i
//   sb_ready_o    block is idle and can accept a new state
//   sb_i          input state, column-major; byte (col c, row r) sits at
//                 [127-32c-8r -: 8]
//   sb_valid_o    sb_o holds a completed result
//   sb_ready_i    downstream accepts sb_o
//   sb_o          substituted state, same byte layout as sb_i
//
// Parameters:
//   NUM_LANES     columns substituted per cycle: 1, 2 or 4.
//                 Latency from acceptance to sb_valid_o is 4/NUM_LANES cycles.
// -----------------------------------------------------------------------------
module sub_bytes_iter #(
    parameter int NUM_LANES = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enc_or_dec_i,
    input  logic         sb_valid_i,
    output logic         sb_ready_o,
    input  logic [127:0] sb_i,
    output logic         sb_valid_o,
    input  logic         sb_ready_i,
    output logic [127:0] sb_o
);

    if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_num_lanes
        $error("sub_bytes_iter: NUM_LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The column counter steps by NUM_LANES and wraps naturally in 2 bits;
    // with four lanes the step is 0 and the single RUN cycle is also the last.
    localparam logic [1:0] CNT_STEP = 2'(NUM_LANES);
    localparam logic [1:0] CNT_LAST = 2'(4 - NUM_LANES);

    // -------------------------------------------------------------------------
    // S-box ROMs (FIPS-197), purely combinational
    // -------------------------------------------------------------------------
    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t       state_q, state_d;
    logic [1:0]   cnt_q,   cnt_d;
    logic         mode_q,  mode_d;
    logic [127:0] in_q,    in_d;
    logic [127:0] sb_q,    sb_d;
    logic [127:0] sb_sub;

    // -------------------------------------------------------------------------
    // Lane datapath: sb_q with columns cnt .. cnt+NUM_LANES-1 replaced by the
    // substituted bytes of the captured state. Only NUM_LANES*4 byte positions
    // see an S-box pair; the column they look at is steered by cnt_q.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [1:0] col;
        logic [3:0] byte_idx;
        logic [6:0] base;
        logic [7:0] in_byte;
        // NOTE: every variable gets a value before any branch or loop can skip
        // it, so the block stays purely combinational (no inferred latch).
        sb_sub   = sb_q;
        col      = '0;
        byte_idx = '0;
        base     = '0;
        in_byte  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            col = cnt_q + 2'(l);
            for (int r = 0; r < 4; r++) begin
                // Byte index k = 4*col + row lives at bit 127-8k; for a 4-bit
                // k the LSB offset 8*(15-k) is just {~k, 3'b000}.
                byte_idx = {col, 2'(r)};
                base     = {~byte_idx, 3'b000};
                in_byte  = in_q[base +: 8];
                sb_sub[base +: 8] = mode_q ? sbox_fwd(in_byte) : sbox_inv(in_byte);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control: next state and register updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        in_d    = in_q;
        sb_d    = sb_q;
        case (state_q)
            IDLE: begin
                if (sb_valid_i) begin
                    in_d    = sb_i;
                    mode_d  = enc_or_dec_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sb_d  = sb_sub;
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b1;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sb_q    <= sb_d;
        end
    end

    // NOTE: the captured input is pure data that is always written on
    // acceptance before it is read, so it carries no reset.
    always_ff @(posedge clk_i) begin
        in_q <= in_d;
    end

    assign sb_ready_o = (state_q == IDLE);
    assign sb_valid_o = (state_q == DONE);
    assign sb_o       = sb_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_iter
//
// Directed self-checking bench for sub_bytes_iter. The main instance uses
// NUM_LANES=1; a second instance with NUM_LANES=4 checks the short latency.
// Expected values are the FIPS-197 Appendix B round-1 SubBytes vectors and
// hand-derived constant patterns.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sub_bytes_iter;

    localparam logic [127:0] PT_VEC  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] CT_VEC  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ZERO    = 128'h0;
    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] ALL_52  = {16{8'h52}};

    logic         clk_i;
    logic         rst_i;
    logic         enc_or_dec_i;
    logic         sb_valid_i;
    logic         sb_ready_o;
    logic [127:0] sb_i;
    logic         sb_valid_o;
    logic         sb_ready_i;
    logic [127:0] sb_o;

    logic         x4_enc;
    logic         x4_valid_i;
    logic         x4_ready_o;
    logic [127:0] x4_sb_i;
    logic         x4_valid_o;
    logic         x4_ready_i;
    logic [127:0] x4_sb_o;

    int n_tests = 0;
    int n_fail  = 0;

    sub_bytes_iter #(.NUM_LANES(1)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enc_or_dec_i (enc_or_dec_i),
        .sb_valid_i   (sb_valid_i),
        .sb_ready_o   (sb_ready_o),
        .sb_i         (sb_i),
        .sb_valid_o   (sb_valid_o),
        .sb_ready_i   (sb_ready_i),
        .sb_o         (sb_o)
    );

    sub_bytes_iter #(.NUM_LANES(4)) u_dut4 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enc_or_dec_i (x4_enc),
        .sb_valid_i   (x4_valid_i),
        .sb_ready_o   (x4_ready_o),
        .sb_i         (x4_sb_i),
        .sb_valid_o   (x4_valid_o),
        .sb_ready_i   (x4_ready_i),
        .sb_o         (x4_sb_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full transaction on the NUM_LANES=1 instance: accept, wait for the
    // result, optionally hold backpressure, then hand the result off.
    task automatic do_op(input string tag, input logic mode, input logic [127:0] din,
                         input logic [127:0] exp, input bit scramble, input int hold);
        int lat;
        check({tag, "_ready_idle"}, 128'(sb_ready_o), 128'd1);
        enc_or_dec_i = mode;
        sb_i         = din;
        sb_valid_i   = 1'b1;
        sb_ready_i   = 1'b0;
        tick();
        sb_valid_i = 1'b0;
        check({tag, "_ready_run"}, 128'(sb_ready_o), 128'd0);
        lat = 0;
        while (!sb_valid_o && lat < 20) begin
            if (scramble) begin
                sb_i         = {$urandom, $urandom, $urandom, $urandom};
                enc_or_dec_i = ~enc_or_dec_i;
                sb_valid_i   = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        sb_valid_i = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'd4);
        check({tag, "_data"}, sb_o, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 128'(sb_valid_o), 128'd1);
            check({tag, "_hold_ready"}, 128'(sb_ready_o), 128'd0);
            check({tag, "_hold_data"}, sb_o, exp);
        end
        sb_ready_i = 1'b1;
        tick();
        sb_ready_i = 1'b0;
        check({tag, "_valid_after_hs"}, 128'(sb_valid_o), 128'd0);
        check({tag, "_ready_after_hs"}, 128'(sb_ready_o), 128'd1);
        check({tag, "_data_retained"}, sb_o, exp);
    endtask

    initial begin
        logic [127:0] b2b_in  [4];
        logic         b2b_md  [4];
        logic [127:0] b2b_exp [4];
        int           acc_cyc [4];
        int           n_acc;
        int           n_res;
        int           cyc;
        int           lat;
        bit           acc_now;

        rst_i        = 1'b1;
        enc_or_dec_i = 1'b1;
        sb_valid_i   = 1'b0;
        sb_i         = '0;
        sb_ready_i   = 1'b0;
        x4_enc       = 1'b1;
        x4_valid_i   = 1'b0;
        x4_sb_i      = '0;
        x4_ready_i   = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        check("reset_ready", 128'(sb_ready_o), 128'd1);
        check("reset_valid", 128'(sb_valid_o), 128'd0);
        check("reset_data", sb_o, ZERO);

        // FIPS-197 round-1 vectors, with 10 cycles of backpressure on the first.
        do_op("enc_fips", 1'b1, PT_VEC, CT_VEC, 1'b0, 10);
        do_op("dec_fips", 1'b0, CT_VEC, PT_VEC, 1'b0, 0);
        do_op("enc_zero", 1'b1, ZERO, ALL_63, 1'b0, 0);
        do_op("dec_zero", 1'b0, ZERO, ALL_52, 1'b0, 0);

        // Inputs churning during RUN must not disturb the result.
        do_op("enc_scramble", 1'b1, PT_VEC, CT_VEC, 1'b1, 0);
        do_op("dec_scramble", 1'b0, CT_VEC, PT_VEC, 1'b1, 0);

        // Reset during the second RUN cycle discards the partial result.
        enc_or_dec_i = 1'b1;
        sb_i         = PT_VEC;
        sb_valid_i   = 1'b1;
        tick();
        sb_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrun_rst_valid", 128'(sb_valid_o), 128'd0);
        check("midrun_rst_ready", 128'(sb_ready_o), 128'd1);
        check("midrun_rst_data", sb_o, ZERO);
        do_op("after_rst", 1'b1, PT_VEC, CT_VEC, 1'b0, 0);

        // Back-to-back with both valid and ready held high.
        b2b_in[0] = PT_VEC; b2b_md[0] = 1'b1; b2b_exp[0] = CT_VEC;
        b2b_in[1] = CT_VEC; b2b_md[1] = 1'b0; b2b_exp[1] = PT_VEC;
        b2b_in[2] = ZERO;   b2b_md[2] = 1'b1; b2b_exp[2] = ALL_63;
        b2b_in[3] = ZERO;   b2b_md[3] = 1'b0; b2b_exp[3] = ALL_52;
        n_acc = 0;
        n_res = 0;
        cyc   = 0;
        sb_ready_i = 1'b1;
        while (n_res < 4 && cyc < 80) begin
            if (n_acc < 4) begin
                sb_i         = b2b_in[n_acc];
                enc_or_dec_i = b2b_md[n_acc];
                sb_valid_i   = 1'b1;
            end else begin
                sb_valid_i = 1'b0;
            end
            acc_now = sb_ready_o && sb_valid_i;
            if (sb_valid_o) begin
                check($sformatf("b2b_data_%0d", n_res), sb_o, b2b_exp[n_res]);
                n_res++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
        end
        sb_valid_i = 1'b0;
        sb_ready_i = 1'b0;
        check("b2b_results", 128'(n_res), 128'd4);
        check("b2b_accepts", 128'(n_acc), 128'd4);
        if (n_acc == 4) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_ii_%0d", i), 128'(acc_cyc[i+1] - acc_cyc[i]), 128'd6);
            end
        end

        // NUM_LANES=4 instance: single-cycle latency, both directions.
        for (int k = 0; k < 2; k++) begin
            check($sformatf("x4_ready_%0d", k), 128'(x4_ready_o), 128'd1);
            x4_enc     = (k == 0);
            x4_sb_i    = (k == 0) ? PT_VEC : CT_VEC;
            x4_valid_i = 1'b1;
            tick();
            x4_valid_i = 1'b0;
            lat = 0;
            while (!x4_valid_o && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("x4_latency_%0d", k), 128'(lat), 128'd1);
            check($sformatf("x4_data_%0d", k), x4_sb_o, (k == 0) ? CT_VEC : PT_VEC);
            x4_ready_i = 1'b1;
            tick();
            x4_ready_i = 1'b0;
            check($sformatf("x4_valid_after_hs_%0d", k), 128'(x4_valid_o), 128'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
